fb_scanout: RTL and testbench

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_scanout.sv | 197 +++++++++++++++++++
 tb/tb_fb_scanout.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Double-buffered frame buffer: the GPU writes the back bank while the front bank
// is streamed out in raster order through a 2-entry valid/ready output buffer.
module fb_scanout #(
   parameter int FB_WIDTH  = 160,
   parameter int FB_HEIGHT = 120
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  fb_x,
   input  logic [7:0]  fb_y,
   input  logic [15:0] fb_color,
   input  logic        fb_write,
   input  logic        swap_req,
   output logic        swap_done,
   output logic [15:0] out_color,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sof,
   output logic        out_eol
);
   localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
   localparam int AW    = $clog2(2 * DEPTH);
   localparam logic [8:0]    W9         = 9'(FB_WIDTH);
   localparam logic [8:0]    H9         = 9'(FB_HEIGHT);
   localparam logic [7:0]    X_LAST     = 8'(FB_WIDTH - 1);
   localparam logic [7:0]    Y_LAST     = 8'(FB_HEIGHT - 1);
   localparam logic [AW-1:0] BANK1_BASE = AW'(DEPTH);

   typedef struct packed {
      logic [15:0] color;
      logic        sof;
      logic        eol;
      logic        last;
   } pix_t;

   typedef enum logic {IDLE, PENDING} swap_state_t;

   // Both banks share one array: bank 1 occupies the upper DEPTH words.
   logic [15:0]  mem [0:2*DEPTH-1];
   logic [15:0]  rd_data_reg;

   swap_state_t  state_reg;
   logic         front_reg;
   logic         swap_done_reg;

   logic [7:0]   x_reg;
   logic [7:0]   y_reg;
   logic [AW-1:0] addr_reg;

   logic         rd_pending_reg;
   logic         rd_sof_reg;
   logic         rd_eol_reg;
   logic         rd_last_reg;

   pix_t         head_reg;
   pix_t         skid_reg;
   logic [1:0]   count_reg;

   logic         wr_en;
   logic [AW-1:0] wr_addr;
   logic         rd_en;
   logic [AW-1:0] rd_addr;
   logic         push;
   logic         pop;
   logic         frame_end;
   logic         swap_fire;
   logic [2:0]   occ;
   pix_t         in_pix;

   always_comb begin
      wr_en   = fb_write && ({1'b0, fb_x} < W9) && ({1'b0, fb_y} < H9);
      wr_addr = AW'(fb_y) * AW'(FB_WIDTH) + AW'(fb_x);
      if (!front_reg)
         wr_addr = wr_addr + BANK1_BASE;
   end

   assign rd_addr   = front_reg ? (addr_reg + BANK1_BASE) : addr_reg;
   assign push      = rd_pending_reg;
   assign pop       = (count_reg != 2'd0) && out_ready;
   assign frame_end = pop && head_reg.last;
   assign swap_fire = (state_reg == PENDING) && frame_end;

   // Reads in flight plus buffered pixels never exceed the two buffer slots.
   // On a swap, prefetched pixels of the old bank are dropped and re-read.
   assign occ   = 3'(count_reg) + 3'(rd_pending_reg) - 3'(pop);
   assign rd_en = !swap_fire && (occ < 3'd2);

   assign in_pix = '{color: rd_data_reg, sof: rd_sof_reg, eol: rd_eol_reg, last: rd_last_reg};

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= fb_color;
      if (rd_en)
         rd_data_reg <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x_reg          <= '0;
         y_reg          <= '0;
         addr_reg       <= '0;
         rd_pending_reg <= 1'b0;
         rd_sof_reg     <= 1'b0;
         rd_eol_reg     <= 1'b0;
         rd_last_reg    <= 1'b0;
      end else begin
         rd_pending_reg <= rd_en;
         if (swap_fire) begin
            x_reg    <= '0;
            y_reg    <= '0;
            addr_reg <= '0;
         end else if (rd_en) begin
            rd_sof_reg  <= (x_reg == 8'd0) && (y_reg == 8'd0);
            rd_eol_reg  <= (x_reg == X_LAST);
            rd_last_reg <= (x_reg == X_LAST) && (y_reg == Y_LAST);
            if (x_reg == X_LAST) begin
               x_reg <= '0;
               if (y_reg == Y_LAST) begin
                  y_reg    <= '0;
                  addr_reg <= '0;
               end else begin
                  y_reg    <= y_reg + 8'd1;
                  addr_reg <= addr_reg + 1'b1;
               end
            end else begin
               x_reg    <= x_reg + 8'd1;
               addr_reg <= addr_reg + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_reg <= 2'd0;
         head_reg  <= '0;
         skid_reg  <= '0;
      end else if (swap_fire) begin
         count_reg <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_reg == 2'd0) begin
                  head_reg  <= in_pix;
                  count_reg <= 2'd1;
               end else begin
                  skid_reg  <= in_pix;
                  count_reg <= 2'd2;
               end
            end
            2'b01: begin
               head_reg  <= skid_reg;
               count_reg <= count_reg - 2'd1;
            end
            2'b11: begin
               if (count_reg == 2'd1) begin
                  head_reg <= in_pix;
               end else begin
                  head_reg <= skid_reg;
                  skid_reg <= in_pix;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg     <= IDLE;
         front_reg     <= 1'b0;
         swap_done_reg <= 1'b0;
      end else begin
         swap_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (swap_req)
                  state_reg <= PENDING;
            end
            PENDING: begin
               if (frame_end) begin
                  state_reg     <= IDLE;
                  front_reg     <= ~front_reg;
                  swap_done_reg <= 1'b1;
               end
            end
         endcase
      end
   end

   assign swap_done = swap_done_reg;
   assign out_valid = (count_reg != 2'd0);
   assign out_color = head_reg.color;
   assign out_sof   = head_reg.sof && out_valid;
   assign out_eol   = head_reg.eol && out_valid;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a 16x6 frame: fill, backpressure, swap, clip,
// coalesce and mid-frame reset, with expected pixels computed from the written patterns.
module tb_fb_scanout;
   localparam int W = 16;
   localparam int H = 6;
   localparam int N = W * H;
   localparam int HOT = W + 1;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  fb_x;
   logic [7:0]  fb_y;
   logic [15:0] fb_color;
   logic        fb_write;
   logic        swap_req;
   logic        swap_done;
   logic [15:0] out_color;
   logic        out_valid;
   logic        out_ready;
   logic        out_sof;
   logic        out_eol;

   always #5 clk = ~clk;

   fb_scanout #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .fb_x      (fb_x),
      .fb_y      (fb_y),
      .fb_color  (fb_color),
      .fb_write  (fb_write),
      .swap_req  (swap_req),
      .swap_done (swap_done),
      .out_color (out_color),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sof   (out_sof),
      .out_eol   (out_eol)
   );

   int          errors = 0;
   int          checks = 0;
   int          swap_cnt = 0;
   int          got_cycles = 0;
   logic        stall_prev = 1'b0;
   logic [17:0] hold_prev = '0;
   logic [15:0] got_color [N];
   logic        got_sof [N];
   logic        got_eol [N];
   logic [15:0] exp_color [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge; drives ready/req, samples, and waits one cycle.
   task automatic tick(input logic rdy, input logic req, output logic acc);
      out_ready = rdy;
      swap_req  = req;
      if (stall_prev)
         chk("stall_hold", 32'({out_valid, out_sof, out_eol, out_color}), 32'({1'b1, hold_prev}));
      acc        = out_valid && rdy;
      stall_prev = out_valid && !rdy;
      hold_prev  = {out_sof, out_eol, out_color};
      if (swap_done)
         swap_cnt++;
      @(negedge clk);
      swap_req = 1'b0;
   endtask

   task automatic wr(input int x, input int y, input logic [15:0] c);
      out_ready = 1'b0;
      fb_x      = 8'(x);
      fb_y      = 8'(y);
      fb_color  = c;
      fb_write  = 1'b1;
      @(negedge clk);
      fb_write  = 1'b0;
   endtask

   task automatic sync_sof();
      int guard = 0;
      logic acc;
      while (!(out_valid && out_sof) && guard < 4 * N) begin
         tick(1'b1, 1'b0, acc);
         guard++;
      end
      chk("sync_sof", 32'(out_valid && out_sof), 32'd1);
   endtask

   task automatic wait_swap(input string tag);
      int base = swap_cnt;
      int guard = 0;
      logic acc;
      while (swap_cnt == base && guard < 4 * N) begin
         tick(1'b1, 1'b0, acc);
         guard++;
      end
      chk(tag, 32'(swap_cnt - base), 32'd1);
   endtask

   // mode 0: ready held high; mode 1: random ready. p0..p2: pixel indices that also pulse swap_req.
   task automatic collect(input int mode, input int n, input int p0, input int p1, input int p2);
      int k = 0;
      int guard = 0;
      logic acc;
      logic rdy;
      logic s;
      logic e;
      logic [15:0] c;
      got_cycles = 0;
      while (k < n && guard < 40 * n) begin
         rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         c = out_color;
         s = out_sof;
         e = out_eol;
         tick(rdy, (mode == 0) && (k == p0 || k == p1 || k == p2), acc);
         if (acc) begin
            got_color[k] = c;
            got_sof[k]   = s;
            got_eol[k]   = e;
            k++;
         end
         guard++;
         got_cycles++;
      end
      chk("collect_count", 32'(k), 32'(n));
   endtask

   task automatic compare_frame(input string tag);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s_color[%0d]", tag, i), 32'(got_color[i]), 32'(exp_color[i]));
         chk($sformatf("%s_sof[%0d]", tag, i), 32'(got_sof[i]), (i == 0) ? 32'd1 : 32'd0);
         chk($sformatf("%s_eol[%0d]", tag, i), 32'(got_eol[i]), (i % W == W - 1) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_sof"}, 32'(out_sof), 32'd0);
      chk({tag, "_eol"}, 32'(out_eol), 32'd0);
      chk({tag, "_color"}, 32'(out_color), 32'd0);
      chk({tag, "_swap_done"}, 32'(swap_done), 32'd0);
   endtask

   task automatic set_exp_bank1();
      for (int i = 0; i < N; i++)
         exp_color[i] = 16'(i);
   endtask

   task automatic set_exp_bank0();
      for (int i = 0; i < N; i++)
         exp_color[i] = (i == HOT) ? 16'hF800 : 16'(16'h4000 + i);
   endtask

   initial begin
      logic acc;
      int   base;
      int   guard;

      rstn      = 1'b0;
      out_ready = 1'b0;
      swap_req  = 1'b0;
      fb_write  = 1'b0;
      fb_x      = '0;
      fb_y      = '0;
      fb_color  = '0;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");

      // Output may not become valid until two edges after release.
      rstn = 1'b1;
      @(negedge clk);
      chk("valid_after_1cyc", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("valid_after_2cyc", 32'(out_valid), 32'd1);
      chk("first_sof", 32'(out_sof), 32'd1);
      chk("first_eol", 32'(out_eol), 32'd0);

      // Bank 1 (back) gets pixel = address; out-of-range writes must not land anywhere.
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            wr(x, y, 16'(y * W + x));
      wr(W, 0, 16'hDEAD);
      wr(0, H, 16'hDEAD);
      wr(255, 255, 16'hDEAD);

      tick(1'b0, 1'b1, acc);
      wait_swap("swap_to_bank1");

      set_exp_bank1();
      sync_sof();
      collect(0, N, -1, -1, -1);
      chk("fill_no_bubble", 32'(got_cycles), 32'(N));
      compare_frame("fill");

      sync_sof();
      collect(1, N, -1, -1, -1);
      compare_frame("backpressure");

      // Bank 0 becomes back: distinct pattern with 0xF800 at (1,1).
      for (int i = 0; i < N; i++)
         wr(i % W, i / W, (i == HOT) ? 16'hF800 : 16'(16'h4000 + i));

      base = swap_cnt;
      set_exp_bank1();
      sync_sof();
      collect(0, N, 3, 30, 60);
      chk("no_swap_before_frame_end", 32'(swap_cnt - base), 32'd0);
      chk("swap_done_after_last_px", 32'(swap_done), 32'd1);
      compare_frame("pre_swap");

      set_exp_bank0();
      sync_sof();
      collect(0, N, -1, -1, -1);
      compare_frame("post_swap");
      chk("post_swap_hot_px", 32'(got_color[HOT]), 32'h0000F800);
      sync_sof();
      collect(0, N, -1, -1, -1);
      compare_frame("post_swap_2nd");
      chk("coalesced_swap_count", 32'(swap_cnt - base), 32'd1);

      // Swap back to bank 1, then reset mid-frame with another swap pending.
      tick(1'b0, 1'b1, acc);
      wait_swap("swap_back_to_bank1");
      set_exp_bank1();
      sync_sof();
      collect(0, 50, -1, -1, -1);
      chk("midframe_px49", 32'(got_color[49]), 32'd49);
      tick(1'b0, 1'b1, acc);
      rstn = 1'b0;
      @(negedge clk);
      chk_outputs_zero("midframe_reset");
      @(negedge clk);
      stall_prev = 1'b0;
      rstn = 1'b1;
      base = swap_cnt;

      guard = 0;
      while (!out_valid && guard < 10) begin
         tick(1'b0, 1'b0, acc);
         guard++;
      end
      chk("restart_valid", 32'(out_valid), 32'd1);
      chk("restart_sof", 32'(out_sof), 32'd1);
      chk("restart_from_bank0", 32'(out_color), 32'h00004000);

      set_exp_bank0();
      collect(0, N, -1, -1, -1);
      compare_frame("after_reset");
      sync_sof();
      collect(0, N, -1, -1, -1);
      chk("pending_swap_discarded", 32'(swap_cnt - base), 32'd0);
      compare_frame("after_reset_2nd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
